// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - operand/result handshake bundle for alu_pipe
// o_flags exists only when ALU_PIPE_FLAGS_EN is defined.
interface alu_pipe_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic               i_valid;
  logic               o_ready;
  logic [NB_DATA-1:0] i_datoA;
  logic [NB_DATA-1:0] i_datoB;
  logic [NB_OP-1:0]   i_operation;
  logic               o_valid;
  logic               i_ready;
  logic [NB_DATA-1:0] o_result;
  logic [NB_DATA-1:0] o_result_hi;
  logic               o_err;
`ifdef ALU_PIPE_FLAGS_EN
  logic [3:0]         o_flags;
`endif

  modport slave (
    input  i_valid, i_datoA, i_datoB, i_operation, i_ready,
`ifdef ALU_PIPE_FLAGS_EN
    output o_flags,
`endif
    output o_ready, o_valid, o_result, o_result_hi, o_err
  );

  modport master (
    output i_valid, i_datoA, i_datoB, i_operation, i_ready,
`ifdef ALU_PIPE_FLAGS_EN
    input  o_flags,
`endif
    input  o_ready, o_valid, o_result, o_result_hi, o_err
  );
endinterface

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered MIPS-funct ALU with iterative MULTU and valid/ready handshakes
// Optional {N,Z,C,V} flags output enabled by defining ALU_PIPE_FLAGS_EN.
module alu_pipe #(
  parameter int NB_DATA  = 8,
  parameter int NB_OP    = 6,
  parameter int NB_SHAMT = $clog2(NB_DATA)
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  alu_pipe_if.slave  bus
);

  localparam int NB_CNT = $clog2(NB_DATA + 1);
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(NB_DATA - 1);
  localparam int MSB = NB_DATA - 1;

  localparam logic [NB_OP-1:0] OP_ADD   = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB   = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND   = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR    = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR   = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR   = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SLL   = NB_OP'(6'b000000);
  localparam logic [NB_OP-1:0] OP_SRL   = NB_OP'(6'b000010);
  localparam logic [NB_OP-1:0] OP_SRA   = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_SLT   = NB_OP'(6'b101010);
  localparam logic [NB_OP-1:0] OP_SLTU  = NB_OP'(6'b101011);
  localparam logic [NB_OP-1:0] OP_MULTU = NB_OP'(6'b011001);

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

  state_t               r_state;
  logic                 r_valid;
  logic [NB_DATA-1:0]   r_result;
  logic [NB_DATA-1:0]   r_result_hi;
  logic                 r_err;
  logic [NB_DATA-1:0]   r_mul_a;
  logic [2*NB_DATA-1:0] r_mul_b;
  logic [2*NB_DATA-1:0] r_acc;
  logic [NB_CNT-1:0]    r_cnt;

  logic                 w_ready;
  logic                 w_accept;
  logic                 w_is_mul;
  logic                 w_hold_load;
  logic [NB_SHAMT-1:0]  w_shamt;
  logic [NB_DATA:0]     w_sum;
  logic [NB_DATA:0]     w_diff;
  logic [NB_DATA-1:0]   w_res;
  logic                 w_err;
  logic                 w_c;
  logic                 w_v;

  assign w_ready     = (r_state == IDLE) && (!r_valid || bus.i_ready);
  assign w_accept    = bus.i_valid && w_ready;
  assign w_is_mul    = (bus.i_operation == OP_MULTU);
  assign w_hold_load = (r_state == HOLD) && (!r_valid || bus.i_ready);
  assign w_shamt     = bus.i_datoB[NB_SHAMT-1:0];
  assign w_sum       = {1'b0, bus.i_datoA} + {1'b0, bus.i_datoB};
  assign w_diff      = {1'b0, bus.i_datoA} - {1'b0, bus.i_datoB};

  always_comb begin
    w_res = '0;
    w_err = 1'b0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (bus.i_operation)
      OP_ADD: begin
        w_res = w_sum[NB_DATA-1:0];
        w_c   = w_sum[NB_DATA];
        w_v   = (bus.i_datoA[MSB] == bus.i_datoB[MSB]) && (w_sum[MSB] != bus.i_datoA[MSB]);
      end
      OP_SUB: begin
        w_res = w_diff[NB_DATA-1:0];
        w_c   = w_diff[NB_DATA];
        w_v   = (bus.i_datoA[MSB] != bus.i_datoB[MSB]) && (w_diff[MSB] != bus.i_datoA[MSB]);
      end
      OP_AND:   w_res = bus.i_datoA & bus.i_datoB;
      OP_OR:    w_res = bus.i_datoA | bus.i_datoB;
      OP_XOR:   w_res = bus.i_datoA ^ bus.i_datoB;
      OP_NOR:   w_res = ~(bus.i_datoA | bus.i_datoB);
      OP_SLL:   w_res = bus.i_datoA << w_shamt;
      OP_SRL:   w_res = bus.i_datoA >> w_shamt;
      OP_SRA:   w_res = $unsigned($signed(bus.i_datoA) >>> w_shamt);
      OP_SLT:   w_res = {{(NB_DATA-1){1'b0}}, ($signed(bus.i_datoA) < $signed(bus.i_datoB))};
      OP_SLTU:  w_res = {{(NB_DATA-1){1'b0}}, (bus.i_datoA < bus.i_datoB)};
      OP_MULTU: w_res = '0;
      default:  w_err = 1'b1;
    endcase
  end

`ifdef ALU_PIPE_FLAGS_EN
  logic [3:0] r_flags;
  logic [3:0] w_flags;
  assign w_flags     = {w_res[MSB], (w_res == '0), w_c, w_v};
  assign bus.o_flags = r_flags;
`else
  logic w_unused_cv;
  assign w_unused_cv = w_c ^ w_v;
`endif

  // Shift-add: r_mul_a walks right one bit per cycle while r_mul_b walks left.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_valid     <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_err       <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
`ifdef ALU_PIPE_FLAGS_EN
      r_flags     <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept && w_is_mul) begin
            r_mul_a <= bus.i_datoA;
            r_mul_b <= {{NB_DATA{1'b0}}, bus.i_datoB};
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= MUL;
          end
        end
        MUL: begin
          if (r_mul_a[0]) r_acc <= r_acc + r_mul_b;
          r_mul_a <= r_mul_a >> 1;
          r_mul_b <= r_mul_b << 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) r_state <= HOLD;
        end
        HOLD: begin
          if (w_hold_load) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // A new result at the consume edge takes priority over clearing o_valid.
      if (w_accept && !w_is_mul) begin
        r_result    <= w_res;
        r_result_hi <= '0;
        r_err       <= w_err;
        r_valid     <= 1'b1;
`ifdef ALU_PIPE_FLAGS_EN
        r_flags     <= w_flags;
`endif
      end else if (w_hold_load) begin
        r_result    <= r_acc[NB_DATA-1:0];
        r_result_hi <= r_acc[2*NB_DATA-1:NB_DATA];
        r_err       <= 1'b0;
        r_valid     <= 1'b1;
`ifdef ALU_PIPE_FLAGS_EN
        r_flags     <= {r_acc[NB_DATA-1], (r_acc == '0), 2'b00};
`endif
      end else if (r_valid && bus.i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.o_ready     = w_ready;
  assign bus.o_valid     = r_valid;
  assign bus.o_result    = r_result;
  assign bus.o_result_hi = r_result_hi;
  assign bus.o_err       = r_err;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed table-driven bench for alu_pipe
// Flag checks are compiled in when ALU_PIPE_FLAGS_EN is defined.
module tb_alu_pipe;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  alu_pipe_if #(.NB_DATA(8), .NB_OP(6)) bus ();

  alu_pipe #(.NB_DATA(8), .NB_OP(6)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       err;
    logic [3:0] flags;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.i_operation = op;
    bus.i_datoA     = a;
    bus.i_datoB     = b;
    bus.i_valid     = 1'b1;
  endtask

  // Runs one MULTU with unrelated traffic held on the inputs, then checks
  // that the pending ADD 3+4 is taken the cycle o_ready returns.
  task automatic mul_run(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_lo, input logic [7:0] exp_hi);
    int  cyc;
    logic busy_ok;
    @(negedge clk);
    drive(6'b011001, a, b);
    @(posedge clk);
    #1;
    drive(6'b100000, 8'h03, 8'h04);
    cyc = 0;
    busy_ok = 1'b1;
    while (!bus.o_valid && cyc < 30) begin
      if (bus.o_ready) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, "_latency"}, cyc, 9);
    check({name, "_busy"}, {31'd0, busy_ok}, 1);
    check({name, "_lo"}, {24'd0, bus.o_result}, {24'd0, exp_lo});
    check({name, "_hi"}, {24'd0, bus.o_result_hi}, {24'd0, exp_hi});
    check({name, "_err"}, {31'd0, bus.o_err}, 0);
    check({name, "_ready_back"}, {31'd0, bus.o_ready}, 1);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    check({name, "_next_valid"}, {31'd0, bus.o_valid}, 1);
    check({name, "_next_res"}, {24'd0, bus.o_result}, 32'h07);
    check({name, "_next_hi"}, {24'd0, bus.o_result_hi}, 0);
  endtask

  initial begin
    int   held;
    logic seen;
    n_checks = 0;
    n_fail   = 0;

    vecs.push_back('{6'b100000, 8'h7F, 8'h01, 8'h80, 1'b0, 4'b1001});
    vecs.push_back('{6'b100010, 8'h00, 8'h01, 8'hFF, 1'b0, 4'b1010});
    vecs.push_back('{6'b100010, 8'h05, 8'h07, 8'hFE, 1'b0, 4'b1010});
    vecs.push_back('{6'b100010, 8'h80, 8'h01, 8'h7F, 1'b0, 4'b0001});
    vecs.push_back('{6'b100000, 8'hFF, 8'h01, 8'h00, 1'b0, 4'b0110});
    vecs.push_back('{6'b000011, 8'h80, 8'h03, 8'hF0, 1'b0, 4'b1000});
    vecs.push_back('{6'b000011, 8'h40, 8'h01, 8'h20, 1'b0, 4'b0000});
    vecs.push_back('{6'b000010, 8'h80, 8'h0B, 8'h10, 1'b0, 4'b0000});
    vecs.push_back('{6'b000000, 8'h01, 8'h0F, 8'h80, 1'b0, 4'b1000});
    vecs.push_back('{6'b101010, 8'hFF, 8'h01, 8'h01, 1'b0, 4'b0000});
    vecs.push_back('{6'b101010, 8'h01, 8'hFF, 8'h00, 1'b0, 4'b0100});
    vecs.push_back('{6'b101011, 8'hFF, 8'h01, 8'h00, 1'b0, 4'b0100});
    vecs.push_back('{6'b100100, 8'hF0, 8'h3C, 8'h30, 1'b0, 4'b0000});
    vecs.push_back('{6'b100101, 8'h0F, 8'h30, 8'h3F, 1'b0, 4'b0000});
    vecs.push_back('{6'b100110, 8'h0F, 8'hFF, 8'hF0, 1'b0, 4'b1000});
    vecs.push_back('{6'b100111, 8'h00, 8'h00, 8'hFF, 1'b0, 4'b1000});
    vecs.push_back('{6'b111111, 8'h12, 8'h34, 8'h00, 1'b1, 4'b0100});
    vecs.push_back('{6'b100000, 8'h01, 8'h01, 8'h02, 1'b0, 4'b0000});

    rst_n           = 1'b0;
    bus.i_valid     = 1'b0;
    bus.i_ready     = 1'b1;
    bus.i_operation = '0;
    bus.i_datoA     = '0;
    bus.i_datoB     = '0;
    #23;
    check("rst_valid", {31'd0, bus.o_valid}, 0);
    check("rst_result", {24'd0, bus.o_result}, 0);
    check("rst_hi", {24'd0, bus.o_result_hi}, 0);
    check("rst_err", {31'd0, bus.o_err}, 0);
    check("rst_ready", {31'd0, bus.o_ready}, 1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_ready", i), {31'd0, bus.o_ready}, 1);
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      check($sformatf("v%0d_valid", i), {31'd0, bus.o_valid}, 1);
      check($sformatf("v%0d_res", i), {24'd0, bus.o_result}, {24'd0, vecs[i].res});
      check($sformatf("v%0d_hi", i), {24'd0, bus.o_result_hi}, 0);
      check($sformatf("v%0d_err", i), {31'd0, bus.o_err}, {31'd0, vecs[i].err});
`ifdef ALU_PIPE_FLAGS_EN
      check($sformatf("v%0d_flags", i), {28'd0, bus.o_flags}, {28'd0, vecs[i].flags});
`endif
    end

    mul_run("mul_ffff", 8'hFF, 8'hFF, 8'h01, 8'hFE);

    @(negedge clk);
    drive(6'b100100, 8'hF0, 8'h3C);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    check("bp_first_res", {24'd0, bus.o_result}, 32'h30);
    held = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (!bus.o_ready && bus.o_valid && bus.o_result == 8'h30) held++;
    end
    check("bp_held_cycles", held, 5);
    @(negedge clk);
    bus.i_ready = 1'b1;
    drive(6'b100101, 8'h01, 8'h02);
    #1;
    check("bp_ready_comb", {31'd0, bus.o_ready}, 1);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    check("bp_new_valid", {31'd0, bus.o_valid}, 1);
    check("bp_new_res", {24'd0, bus.o_result}, 32'h03);
    @(posedge clk);
    #1;
    check("bp_consumed", {31'd0, bus.o_valid}, 0);

    @(negedge clk);
    drive(6'b011001, 8'h0F, 8'h0F);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, bus.o_valid}, 0);
    check("arst_result", {24'd0, bus.o_result}, 0);
    check("arst_hi", {24'd0, bus.o_result_hi}, 0);
    check("arst_err", {31'd0, bus.o_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.o_valid || bus.o_result == 8'hE1) seen = 1'b1;
    end
    check("arst_no_ghost", {31'd0, seen}, 0);
    check("arst_ready", {31'd0, bus.o_ready}, 1);

    mul_run("mul_0f0f", 8'h0F, 8'h0F, 8'hE1, 8'h00);
    mul_run("mul_0c0a", 8'h0C, 8'h0A, 8'h78, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
